// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared types for the data memory controller and its write buffer.
// The entry fields are sized by MC_ADDR_WIDTH/MC_DATA_WIDTH; the controller's width
// parameters default to these and must be kept equal to them.
package data_mem_ctrl_pkg;

    localparam int MC_ADDR_WIDTH = 8;
    localparam int MC_DATA_WIDTH = 16;

    // Wide enough for WAIT_STATES up to 7.
    localparam int WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } mctrl_state_e;

    typedef struct packed {
        logic [MC_ADDR_WIDTH-1:0] addr;
        logic [MC_DATA_WIDTH-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/data_mem_ctrl_wbuf_fifo.sv
// wbuf_fifo: posted-write buffer for data_mem_ctrl.
// Ring buffer with a count register; full/empty come from the count.
// With DATA_MEM_CTRL_FWD_EN defined it also offers a youngest-match address lookup.
module wbuf_fifo
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    output wbuf_entry_t head,
    output logic        full,
    output logic        empty
`ifdef DATA_MEM_CTRL_FWD_EN
    ,
    input  logic [MC_ADDR_WIDTH-1:0] lookup_addr,
    output logic                     hit,
    output logic [MC_DATA_WIDTH-1:0] hit_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Entry storage is written at the tail; it needs no reset because count qualifies it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally (power-of-two depth); a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef DATA_MEM_CTRL_FWD_EN
    logic [PTR_W-1:0] lookup_idx;

    // Walk from oldest to youngest valid entry so the last match (the youngest) wins.
    always_comb begin
        hit        = 1'b0;
        hit_data   = '0;
        lookup_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lookup_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem[lookup_idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = mem[lookup_idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: CPU data-port controller in front of a synchronous single-port SRAM.
// Writes are posted into wbuf_fifo and drained in the background; reads go to SRAM
// with WAIT_STATES extra cycles. Optional macro DATA_MEM_CTRL_FWD_EN enables forwarding
// of read hits from the write buffer; without it, a read that finds the buffer non-empty
// first waits for the buffer to drain completely.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = MC_ADDR_WIDTH,
    parameter int DATA_WIDTH  = MC_DATA_WIDTH,
    parameter int WAIT_STATES = 1,
    parameter int WBUF_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_re_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_rvalid_o,
    output logic                  cpu_busy_o,
    output logic                  cpu_wfull_o,
    output logic                  sram_cs_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES);

    mctrl_state_e          state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  access_done;
    logic                  we_acc;
    logic                  re_acc;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    wbuf_entry_t           push_entry;
    wbuf_entry_t           head;

    assign access_done      = (wait_cnt == WAIT_LAST);
    assign we_acc           = cpu_we_i & ~fifo_full & rst_i;
    assign re_acc           = cpu_re_i & ~cpu_busy_o;
    assign pop              = (state == WR) & access_done;
    assign push_entry.addr  = cpu_addr_i;
    assign push_entry.data  = cpu_wdata_i;
    assign cpu_wfull_o      = fifo_full;

`ifdef DATA_MEM_CTRL_FWD_EN
    logic                  buf_hit;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // A write accepted in the same cycle shares the read address and is the youngest entry.
    assign fwd_hit    = we_acc | buf_hit;
    assign fwd_data   = we_acc ? cpu_wdata_i : buf_data;
    assign cpu_busy_o = (state != IDLE) | ~rst_i;
`else
    logic                  rd_pending;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    // A read parked behind the drain keeps the CPU stalled even while passing through IDLE.
    assign cpu_busy_o = (state != IDLE) | rd_pending | ~rst_i;
`endif

    wbuf_fifo #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .push        (we_acc),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty)
`ifdef DATA_MEM_CTRL_FWD_EN
        ,
        .lookup_addr (cpu_addr_i),
        .hit         (buf_hit),
        .hit_data    (buf_data)
`endif
    );

    // Access FSM: issues registered SRAM cycles, counts wait states and returns read data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            sram_cs_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            cpu_rvalid_o <= 1'b0;
            cpu_rdata_o  <= '0;
`ifndef DATA_MEM_CTRL_FWD_EN
            rd_pending   <= 1'b0;
            rd_addr_q    <= '0;
`endif
        end else begin
            cpu_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
`ifdef DATA_MEM_CTRL_FWD_EN
                    if (re_acc && fwd_hit) begin
                        cpu_rvalid_o <= 1'b1;
                        cpu_rdata_o  <= fwd_data;
                    end else if (re_acc) begin
                        state       <= RD;
                        sram_cs_o   <= 1'b1;
                        sram_we_o   <= 1'b0;
                        sram_addr_o <= cpu_addr_i;
                    end else if (!fifo_empty) begin
                        state        <= WR;
                        sram_cs_o    <= 1'b1;
                        sram_we_o    <= 1'b1;
                        sram_addr_o  <= head.addr;
                        sram_wdata_o <= head.data;
                    end
`else
                    if (re_acc) begin
                        if (fifo_empty && !we_acc) begin
                            state       <= RD;
                            sram_cs_o   <= 1'b1;
                            sram_we_o   <= 1'b0;
                            sram_addr_o <= cpu_addr_i;
                        end else begin
                            rd_pending <= 1'b1;
                            rd_addr_q  <= cpu_addr_i;
                            if (!fifo_empty) begin
                                state        <= WR;
                                sram_cs_o    <= 1'b1;
                                sram_we_o    <= 1'b1;
                                sram_addr_o  <= head.addr;
                                sram_wdata_o <= head.data;
                            end
                        end
                    end else if (!fifo_empty) begin
                        state        <= WR;
                        sram_cs_o    <= 1'b1;
                        sram_we_o    <= 1'b1;
                        sram_addr_o  <= head.addr;
                        sram_wdata_o <= head.data;
                    end else if (rd_pending) begin
                        rd_pending  <= 1'b0;
                        state       <= RD;
                        sram_cs_o   <= 1'b1;
                        sram_we_o   <= 1'b0;
                        sram_addr_o <= rd_addr_q;
                    end
`endif
                end
                RD: begin
                    if (access_done) begin
                        state        <= IDLE;
                        sram_cs_o    <= 1'b0;
                        cpu_rvalid_o <= 1'b1;
                        cpu_rdata_o  <= sram_rdata_i;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                WR: begin
                    if (access_done) begin
                        state     <= IDLE;
                        sram_cs_o <= 1'b0;
                        sram_we_o <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    sram_cs_o <= 1'b0;
                    sram_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench for data_mem_ctrl with a behavioural SRAM.
// Expectations follow DATA_MEM_CTRL_FWD_EN when it is defined for the build.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_re;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_busy;
    logic        cpu_wfull;
    logic        sram_cs;
    logic        sram_we;
    logic [7:0]  sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sram [256];
    logic [23:0] wlog[$];
    int          cyc = 0;
    int          sram_rd_cycles = 0;
    int          vectors = 0;
    int          miscompares = 0;

    localparam int MISS_LAT = 3;
`ifdef DATA_MEM_CTRL_FWD_EN
    localparam int HIT_LAT      = 1;
    localparam int T2_RD_CYCLES = 0;
`else
    localparam int HIT_LAT      = -1;
    localparam int T2_RD_CYCLES = 2;
`endif

    data_mem_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_re_i     (cpu_re),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_busy_o   (cpu_busy),
        .cpu_wfull_o  (cpu_wfull),
        .sram_cs_o    (sram_cs),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAM: data readable whenever addressed; writes and read cycles are logged.
    assign sram_rdata = sram[sram_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_cs && !sram_we) begin
            sram_rd_cycles <= sram_rd_cycles + 1;
        end
        if (sram_cs && sram_we) begin
            sram[sram_addr] <= sram_wdata;
            if (wlog.size() == 0 || wlog[$] != {sram_addr, sram_wdata}) begin
                wlog.push_back({sram_addr, sram_wdata});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one cycle of CPU request; a read pushes its expected response to the scoreboard.
    task automatic applyStimulus(input logic re, input logic we, input logic [7:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] exp_data, input int lat);
        exp_t e;
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (re) begin
            e.data = exp_data;
            e.cyc  = (lat < 0) ? -1 : cyc + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (cpu_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", {31'b0, cpu_busy}, 32'd0);
    endtask

    task automatic drainReads(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reads_outstanding", exp_q.size(), 32'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, {27'b0, sram_cs, sram_we, cpu_rvalid, cpu_wfull, cpu_busy}, 32'h1);
        checkOutput({tag, "_sram_addr"}, {24'b0, sram_addr}, 32'h0);
        checkOutput({tag, "_sram_wdata"}, {16'b0, sram_wdata}, 32'h0);
        checkOutput({tag, "_rdata"}, {16'b0, cpu_rdata}, 32'h0);
    endtask

    // Monitor: every read-data strobe is matched against the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_rvalid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rvalid", {31'b0, cpu_rvalid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rdata", {16'b0, cpu_rdata}, {16'b0, e.data});
                    if (e.cyc >= 0) begin
                        checkOutput("rvalid_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: bench did not complete, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = '0;
        sram[8'h10] = 16'hBEEF;
        sram[8'h40] = 16'hDEAD;
        sram[8'h50] = 16'h5A5A;
        rst       = 1'b0;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;

        $display("[TB] test 1: read miss from idle");
        sram_rd_cycles = 0;
        applyStimulus(1'b1, 1'b0, 8'h10, 16'h0, 16'hBEEF, MISS_LAT);
        drainReads(20);
        checkOutput("t1_sram_rd_cycles", sram_rd_cycles, 32'd2);

        $display("[TB] test 2: write then read same address");
        settle(2);
        sram_rd_cycles = 0;
        applyStimulus(1'b0, 1'b1, 8'h20, 16'h1234, 16'h0, 0);
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0, 16'h1234, HIT_LAT);
        drainReads(30);
        settle(10);
        checkOutput("t2_sram_rd_cycles", sram_rd_cycles, T2_RD_CYCLES);
        checkOutput("t2_sram_20", {16'b0, sram[8'h20]}, 32'h1234);

        $display("[TB] test 3: three writes to one address then read");
        wlog.delete();
        applyStimulus(1'b0, 1'b1, 8'h30, 16'd1, 16'h0, 0);
        applyStimulus(1'b0, 1'b1, 8'h30, 16'd2, 16'h0, 0);
        applyStimulus(1'b0, 1'b1, 8'h30, 16'd3, 16'h0, 0);
        waitIdle(20);
        applyStimulus(1'b1, 1'b0, 8'h30, 16'h0, 16'd3, -1);
        drainReads(40);
        settle(10);
        checkOutput("t3_sram_30", {16'b0, sram[8'h30]}, 32'd3);
        checkOutput("t3_wlog_size", wlog.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wlog.size()) begin
                checkOutput("t3_wlog_order", {8'b0, wlog[i]}, {8'b0, 8'h30, 16'(i + 1)});
            end
        end

        $display("[TB] test 4: fill buffer behind a read");
        wlog.delete();
        applyStimulus(1'b1, 1'b0, 8'h50, 16'h0, 16'h5A5A, MISS_LAT);
        applyStimulus(1'b0, 1'b1, 8'h60, 16'hA000, 16'h0, 0);
        applyStimulus(1'b0, 1'b1, 8'h61, 16'hA001, 16'h0, 0);
        applyStimulus(1'b0, 1'b1, 8'h62, 16'hA002, 16'h0, 0);
        applyStimulus(1'b0, 1'b1, 8'h63, 16'hA003, 16'h0, 0);
        checkOutput("t4_wfull_after_4", {31'b0, cpu_wfull}, 32'd1);
        applyStimulus(1'b0, 1'b1, 8'h64, 16'hA004, 16'h0, 0);
        drainReads(20);
        settle(20);
        checkOutput("t4_wfull_drained", {31'b0, cpu_wfull}, 32'd0);
        checkOutput("t4_busy_drained", {31'b0, cpu_busy}, 32'd0);
        checkOutput("t4_wlog_size", wlog.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                checkOutput("t4_wlog_order", {8'b0, wlog[i]}, {8'b0, 8'(8'h60 + i), 16'(16'hA000 + i)});
            end
        end
        checkOutput("t4_sram_64", {16'b0, sram[8'h64]}, 32'h0);

        $display("[TB] test 5: simultaneous read and write");
        applyStimulus(1'b1, 1'b1, 8'h40, 16'h00AA, 16'h00AA, HIT_LAT);
        drainReads(30);
        settle(10);
        checkOutput("t5_sram_40", {16'b0, sram[8'h40]}, 32'h00AA);

        $display("[TB] test 6: reset during a drain");
        wlog.delete();
        applyStimulus(1'b0, 1'b1, 8'h70, 16'hC000, 16'h0, 0);
        applyStimulus(1'b0, 1'b1, 8'h71, 16'hC001, 16'h0, 0);
        applyStimulus(1'b0, 1'b1, 8'h72, 16'hC002, 16'h0, 0);
        checkOutput("t6_in_write", {30'b0, sram_cs, sram_we}, 32'h3);
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("t6_reset");
        rst = 1'b1;
        settle(20);
        checkOutput("t6_wlog_size", wlog.size(), 32'd1);
        if (wlog.size() > 0) begin
            checkOutput("t6_wlog0", {8'b0, wlog[0]}, {8'b0, 8'h70, 16'hC000});
        end
        checkOutput("t6_sram_71", {16'b0, sram[8'h71]}, 32'h0);
        checkOutput("t6_sram_72", {16'b0, sram[8'h72]}, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h71, 16'h0, 16'h0000, MISS_LAT);
        drainReads(20);

        settle(5);
        checkOutput("reads_outstanding_end", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
